// File: rtl/sm_msg_scheduler_pkg.sv
// rtl/sm_msg_scheduler_pkg.sv - shared constants, types and byte table for the message scheduler
//
// Purpose: ASCII characters, message length, colour codes, FSM state type and
// the byte-table lookup used to serialise one event into "SI-<n>-<c>-#".
// Ports: none (package).

package sm_msg_scheduler_pkg;

  localparam logic [7:0] CH_S    = 8'h53;
  localparam logic [7:0] CH_I    = 8'h49;
  localparam logic [7:0] CH_DASH = 8'h2D;
  localparam logic [7:0] CH_HASH = 8'h23;
  localparam logic [7:0] CH_R    = 8'h52;
  localparam logic [7:0] CH_G    = 8'h47;
  localparam logic [7:0] CH_B    = 8'h42;
  localparam logic [7:0] CH_ZERO = 8'h30;

  localparam int MSG_LEN = 8;

  localparam logic [1:0] COL_NONE = 2'd0;
  localparam logic [1:0] COL_R    = 2'd1;
  localparam logic [1:0] COL_G    = 2'd2;
  localparam logic [1:0] COL_B    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  typedef struct packed {
    logic [1:0] si;
    logic [1:0] color;
  } ev_t;

  // Character at position idx of the message for event ev.
  function automatic logic [7:0] msg_byte(input logic [2:0] idx, input ev_t ev);
    logic [7:0] ch;
    case (idx)
      3'd0: ch = CH_S;
      3'd1: ch = CH_I;
      3'd3: ch = CH_ZERO + {6'd0, ev.si};
      3'd5: begin
        case (ev.color)
          COL_R:   ch = CH_R;
          COL_G:   ch = CH_G;
          default: ch = CH_B;  // only qualified colours are ever queued
        endcase
      end
      3'd7:    ch = CH_HASH;
      default: ch = CH_DASH;
    endcase
    return ch;
  endfunction

endpackage

// File: rtl/sm_msg_scheduler_fifo.sv
// rtl/sm_msg_scheduler_fifo.sv - synchronous event FIFO holding {si, color} entries
//
// Purpose: small power-of-two FIFO with combinational head output.
// Ports: clk, rst (sync active-high), push, pop, din[3:0], dout[3:0], empty, full.
// A push while full or a pop while empty is ignored.

module sm_event_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [3:0] din,
  output logic [3:0] dout,
  output logic       empty,
  output logic       full
);

  localparam int AW = $clog2(DEPTH);

  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sm_msg_scheduler.sv
// rtl/sm_msg_scheduler.sv - qualifies status events and serialises them to the UART
//
// Purpose: drops invalid/duplicate events, buffers the rest, and sends each as
// the 8-byte message "SI-<n>-<c>-#" over a tx_start level / tx_done pulse handshake.
// Ports: clk, rst (sync active-high); ev_valid, ev_si[1:0], ev_color[1:0] event in;
// tx_done from UART; tx_data[7:0], tx_start to UART; busy, overflow (sticky),
// msg_count[CNT_W-1:0] status.

module sm_msg_scheduler
  import sm_msg_scheduler_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ev_valid,
  input  logic [1:0]       ev_si,
  input  logic [1:0]       ev_color,
  input  logic             tx_done,
  output logic [7:0]       tx_data,
  output logic             tx_start,
  output logic             busy,
  output logic             overflow,
  output logic [CNT_W-1:0] msg_count
);

  state_t     state;
  ev_t        ev_in;
  ev_t        last_ev;
  ev_t        msg;
  ev_t        fifo_dout;
  logic [2:0] byte_idx;
  logic       fifo_empty;
  logic       fifo_full;
  logic       qual;
  logic       push;
  logic       pop;

  assign ev_in = {ev_si, ev_color};

  // Qualified = well-formed and different from the last pair actually queued.
  assign qual = ev_valid && (ev_si != 2'd0) && (ev_color != COL_NONE) && (ev_in != last_ev);
  assign push = qual && !fifo_full;
  assign pop  = (state == ST_IDLE) && !fifo_empty;
  assign busy = (state != ST_IDLE) || !fifo_empty;

  sm_event_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (ev_in),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      last_ev  <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) last_ev <= ev_in;
      // A dropped event leaves last_ev alone so a retry after drain is accepted.
      if (qual && fifo_full) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      tx_start  <= 1'b0;
      tx_data   <= 8'h00;
      msg       <= '0;
      byte_idx  <= 3'd0;
      msg_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            msg      <= fifo_dout;
            byte_idx <= 3'd0;
            tx_data  <= msg_byte(3'd0, fifo_dout);
            tx_start <= 1'b1;
            state    <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (tx_done) begin
            tx_start <= 1'b0;
            if (byte_idx == 3'(MSG_LEN - 1)) begin
              msg_count <= msg_count + CNT_W'(1);
              state     <= ST_IDLE;
            end else begin
              byte_idx <= byte_idx + 3'd1;
              state    <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          // One low cycle so the UART sees a fresh request edge.
          tx_data  <= msg_byte(byte_idx, msg);
          tx_start <= 1'b1;
          state    <= ST_SEND;
        end
        default: begin
          tx_start <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
